// File: rtl/vc_input_arbiter_pkg.sv
// =====================================================================
// vc_input_arbiter_pkg -- shared defaults, FSM encoding, flit record.
// Rev 1.0
// =====================================================================
`default_nettype none

package vc_input_arbiter_pkg;

  localparam int FLIT_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_flags_t;

  typedef struct packed {
    logic [FLIT_W_DEF-1:0] payload;
    logic                  head;
    logic                  tail;
  } flit_t;

endpackage

`default_nettype wire

// File: rtl/vc_input_arbiter_if.sv
// =====================================================================
// vc_input_arbiter_if -- two VC input ports, output handshake, err flag.
// Rev 1.0
// =====================================================================
`default_nettype none

interface vc_input_arbiter_if
  import vc_input_arbiter_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF
);
  logic              in0_valid;
  logic [FLIT_W-1:0] in0_flit;
  logic              in0_head;
  logic              in0_tail;
  logic              in0_ready;
  logic              in1_valid;
  logic [FLIT_W-1:0] in1_flit;
  logic              in1_head;
  logic              in1_tail;
  logic              in1_ready;
  logic [FLIT_W-1:0] vc0_flit;
  logic [FLIT_W-1:0] vc1_flit;
  logic              sel;
  logic              out_valid;
  logic              out_head;
  logic              out_tail;
  logic              out_ready;
  logic              err;

  modport master (
    output in0_valid, in0_flit, in0_head, in0_tail,
    output in1_valid, in1_flit, in1_head, in1_tail,
    output out_ready,
    input  in0_ready, in1_ready, vc0_flit, vc1_flit,
    input  sel, out_valid, out_head, out_tail, err
  );

  modport slave (
    input  in0_valid, in0_flit, in0_head, in0_tail,
    input  in1_valid, in1_flit, in1_head, in1_tail,
    input  out_ready,
    output in0_ready, in1_ready, vc0_flit, vc1_flit,
    output sel, out_valid, out_head, out_tail, err
  );

endinterface

`default_nettype wire

// File: rtl/vc_input_arbiter_vc_fifo.sv
// =====================================================================
// vc_fifo -- per-VC synchronous flit FIFO; head reads as zero when empty.
// Rev 1.0
// =====================================================================
`default_nettype none

module vc_fifo
  import vc_input_arbiter_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_payload,
  input  flit_flags_t       push_flags,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head_payload,
  output flit_flags_t       head_flags
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [FLIT_W-1:0] r_payload [DEPTH];
  flit_flags_t       r_flags   [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_payload[r_wr_ptr] <= push_payload;
      r_flags[r_wr_ptr]   <= push_flags;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_payload = empty ? '0 : r_payload[r_rd_ptr];
  assign head_flags   = empty ? '0 : r_flags[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/vc_input_arbiter.sv
// =====================================================================
// vc_input_arbiter -- two-VC wormhole input arbiter with round-robin grant.
// Rev 1.0
// =====================================================================
`default_nettype none

module vc_input_arbiter
  import vc_input_arbiter_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  vc_input_arbiter_if.slave bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_sel;
  logic              w_sel_nxt;
  logic              r_rr;
  logic              w_rr_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_live;

  logic              w_full0, w_full1;
  logic              w_empty0, w_empty1;
  logic [FLIT_W-1:0] w_pl0, w_pl1;
  flit_flags_t       w_fl0, w_fl1;
  logic              w_pop0, w_pop1;
  logic              w_push0, w_push1;
  logic              w_hd0, w_hd1;
  logic              w_out_valid, w_out_head, w_out_tail;

  // ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  assign bus.in0_ready = r_live && !w_full0;
  assign bus.in1_ready = r_live && !w_full1;
  assign w_push0       = bus.in0_valid && bus.in0_ready;
  assign w_push1       = bus.in1_valid && bus.in1_ready;

  vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (w_push0),
    .push_payload (bus.in0_flit),
    .push_flags   ({bus.in0_head, bus.in0_tail}),
    .pop          (w_pop0),
    .full         (w_full0),
    .empty        (w_empty0),
    .head_payload (w_pl0),
    .head_flags   (w_fl0)
  );

  vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (w_push1),
    .push_payload (bus.in1_flit),
    .push_flags   ({bus.in1_head, bus.in1_tail}),
    .pop          (w_pop1),
    .full         (w_full1),
    .empty        (w_empty1),
    .head_payload (w_pl1),
    .head_flags   (w_fl1)
  );

  assign w_hd0 = !w_empty0 && w_fl0.head;
  assign w_hd1 = !w_empty1 && w_fl1.head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_rr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rr    <= w_rr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr;
    w_err_nxt   = r_err;
    w_pop0      = 1'b0;
    w_pop1      = 1'b0;
    w_out_valid = 1'b0;
    w_out_head  = 1'b0;
    w_out_tail  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // orphan body flits at a FIFO head cannot start a packet: drop them
        if (!w_empty0 && !w_fl0.head) begin
          w_pop0    = 1'b1;
          w_err_nxt = 1'b1;
        end
        if (!w_empty1 && !w_fl1.head) begin
          w_pop1    = 1'b1;
          w_err_nxt = 1'b1;
        end
        if (w_hd0 && (!w_hd1 || !r_rr)) begin
          w_state_nxt = ST_LOCK0;
          w_sel_nxt   = 1'b0;
        end else if (w_hd1) begin
          w_state_nxt = ST_LOCK1;
          w_sel_nxt   = 1'b1;
        end
      end
      ST_LOCK0: begin
        w_out_valid = !w_empty0;
        w_out_head  = w_fl0.head;
        w_out_tail  = w_fl0.tail;
        w_pop0      = w_out_valid && bus.out_ready;
        if (w_pop0 && w_fl0.tail) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = 1'b1;
        end
      end
      ST_LOCK1: begin
        w_out_valid = !w_empty1;
        w_out_head  = w_fl1.head;
        w_out_tail  = w_fl1.tail;
        w_pop1      = w_out_valid && bus.out_ready;
        if (w_pop1 && w_fl1.tail) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.vc0_flit  = w_pl0;
  assign bus.vc1_flit  = w_pl1;
  assign bus.sel       = r_sel;
  assign bus.out_valid = w_out_valid;
  assign bus.out_head  = w_out_head;
  assign bus.out_tail  = w_out_tail;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vc_input_arbiter.sv
// =====================================================================
// tb_vc_input_arbiter -- directed self-checking bench for vc_input_arbiter.
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_vc_input_arbiter;
  import vc_input_arbiter_pkg::*;

  typedef struct packed {
    logic  sel;
    flit_t f;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  xfer_t q[$];

  vc_input_arbiter_if #(.FLIT_W(32)) bus ();

  vc_input_arbiter #(.FLIT_W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge sample predicts the transfer
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      q.push_back({bus.sel, (bus.sel ? bus.vc1_flit : bus.vc0_flit), bus.out_head, bus.out_tail});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] pl, input logic h, input logic t);
    bus.in0_valid = v; bus.in0_flit = pl; bus.in0_head = h; bus.in0_tail = t;
  endtask

  task automatic drive1(input logic v, input logic [31:0] pl, input logic h, input logic t);
    bus.in1_valid = v; bus.in1_flit = pl; bus.in1_head = h; bus.in1_tail = t;
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (q.size() >= n) break;
      tick();
    end
    check(tag, 64'(q.size() >= n), 64'd1);
  endtask

  task automatic chk_xfer(input string tag, input logic vc, input logic [31:0] pl,
                          input logic h, input logic t);
    xfer_t x;
    xfer_t e;
    e = {vc, pl, h, t};
    if (q.size() == 0) begin
      check(tag, 64'd0, 64'(e));
    end else begin
      x = q.pop_front();
      check(tag, 64'(x), 64'(e));
    end
  endtask

  initial begin
    int i;
    int stalls;
    int guard;

    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_in0_ready", 64'(bus.in0_ready), 64'd0);
    check("rst_in1_ready", 64'(bus.in1_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_vc0_flit", 64'(bus.vc0_flit), 64'd0);
    check("rst_vc1_flit", 64'(bus.vc1_flit), 64'd0);
    check("rst_sel", 64'(bus.sel), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in0_ready", 64'(bus.in0_ready), 64'd1);
    check("rel_in1_ready", 64'(bus.in1_ready), 64'd1);

    // two 3-flit packets offered together, rr=0 -> VC0 first, then VC1
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive0(1'b1, 32'h10 + 32'(k), k == 0, k == 2);
      drive1(1'b1, 32'h20 + 32'(k), k == 0, k == 2);
      tick();
    end
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    wait_q("both_wait", 6, 40);
    for (int k = 0; k < 3; k++) chk_xfer("both_vc0", 1'b0, 32'h10 + 32'(k), k == 0, k == 2);
    for (int k = 0; k < 3; k++) chk_xfer("both_vc1", 1'b1, 32'h20 + 32'(k), k == 0, k == 2);
    repeat (3) tick();

    // single head+tail flit on VC0, cycle-accurate latency
    drive0(1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
    tick();
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    check("single_n1_valid", 64'(bus.out_valid), 64'd0);
    check("single_n1_vc0", 64'(bus.vc0_flit), 64'hA5A5_0001);
    tick();
    check("single_n2_valid", 64'(bus.out_valid), 64'd1);
    check("single_n2_sel", 64'(bus.sel), 64'd0);
    check("single_n2_ht", 64'({bus.out_head, bus.out_tail}), 64'd3);
    check("single_n2_vc0", 64'(bus.vc0_flit), 64'hA5A5_0001);
    tick();
    check("single_n3_valid", 64'(bus.out_valid), 64'd0);
    check("single_n3_vc0", 64'(bus.vc0_flit), 64'd0);
    chk_xfer("single_xfer", 1'b0, 32'hA5A5_0001, 1'b1, 1'b1);
    repeat (2) tick();

    // rr now points at VC1: simultaneous single-flit packets -> VC1 wins
    drive0(1'b1, 32'h31, 1'b1, 1'b1);
    drive1(1'b1, 32'h41, 1'b1, 1'b1);
    tick();
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    wait_q("rr_wait", 2, 20);
    chk_xfer("rr_first", 1'b1, 32'h41, 1'b1, 1'b1);
    chk_xfer("rr_second", 1'b0, 32'h31, 1'b1, 1'b1);
    repeat (3) tick();

    // fill VC1 with out_ready low, 5th flit must be refused
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive1(1'b1, 32'h50 + 32'(k), k == 0, k == 3);
      tick();
      if (k == 2) check("fill_ready_3", 64'(bus.in1_ready), 64'd1);
    end
    check("fill_ready_4", 64'(bus.in1_ready), 64'd0);
    drive1(1'b1, 32'h54, 1'b0, 1'b0);
    tick(); tick();
    check("fill_ready_hold", 64'(bus.in1_ready), 64'd0);
    check("fill_valid_hold", 64'(bus.out_valid), 64'd1);
    check("fill_sel", 64'(bus.sel), 64'd1);
    check("fill_vc1", 64'(bus.vc1_flit), 64'h50);
    drive1(1'b0, 32'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    wait_q("fill_wait", 4, 20);
    for (int k = 0; k < 4; k++) chk_xfer("fill_xfer", 1'b1, 32'h50 + 32'(k), k == 0, k == 3);
    repeat (4) tick();
    check("fill_no_5th", 64'(q.size()), 64'd0);
    check("fill_err", 64'(bus.err), 64'd0);

    // orphan body flit on VC0 in IDLE
    drive0(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    check("orphan_err0", 64'(bus.err), 64'd0);
    check("orphan_vc0", 64'(bus.vc0_flit), 64'hFF);
    tick();
    check("orphan_err1", 64'(bus.err), 64'd1);
    check("orphan_valid", 64'(bus.out_valid), 64'd0);
    check("orphan_popped", 64'(bus.vc0_flit), 64'd0);
    repeat (3) tick();
    check("orphan_sticky", 64'(bus.err), 64'd1);
    check("orphan_noxfer", 64'(q.size()), 64'd0);

    // reset after two of three flits transferred
    drive0(1'b1, 32'h60, 1'b1, 1'b0);
    tick();
    drive0(1'b1, 32'h61, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    wait_q("mid_wait", 2, 20);
    chk_xfer("mid_xfer0", 1'b0, 32'h60, 1'b1, 1'b0);
    chk_xfer("mid_xfer1", 1'b0, 32'h61, 1'b0, 1'b0);
    drive0(1'b1, 32'h62, 1'b0, 1'b1);
    tick();
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    check("mid_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ht", 64'({bus.out_head, bus.out_tail}), 64'd0);
    check("mid_rst_vc0", 64'(bus.vc0_flit), 64'd0);
    check("mid_rst_ready", 64'(bus.in0_ready), 64'd0);
    check("mid_rst_err", 64'(bus.err), 64'd0);
    check("mid_rst_sel", 64'(bus.sel), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_ready", 64'(bus.in0_ready), 64'd1);
    repeat (6) tick();
    check("mid_no_tail", 64'(q.size()), 64'd0);
    check("mid_idle_valid", 64'(bus.out_valid), 64'd0);

    // 20-flit packet at full rate on VC0: pointers wrap, no back-pressure
    i = 0;
    stalls = 0;
    guard = 0;
    while (i < 20 && guard < 200) begin
      drive0(1'b1, 32'h100 + 32'(i), i == 0, i == 19);
      if (!bus.in0_ready) stalls++;
      else i++;
      tick();
      guard++;
    end
    drive0(1'b0, 32'h0, 1'b0, 1'b0);
    check("stream_pushed", 64'(i), 64'd20);
    check("stream_stalls", 64'(stalls), 64'd0);
    wait_q("stream_wait", 20, 40);
    for (int k = 0; k < 20; k++) chk_xfer("stream_xfer", 1'b0, 32'h100 + 32'(k), k == 0, k == 19);
    repeat (3) tick();
    check("stream_idle", 64'(bus.out_valid), 64'd0);
    check("stream_err", 64'(bus.err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_input_arbiter.md
VC_INPUT_ARBITER -- requirements
Module: vc_input_arbiter

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit payload width (matches the 2-line output mux data width).
REQ-002 SHALL have parameter DEPTH, default 4, per-VC FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in0_valid / in1_valid  input  1  flit offered on VC0 / VC1.
REQ-006 SHALL have ports in0_flit / in1_flit  input  FLIT_W  flit payload per VC.
REQ-007 SHALL have ports in0_head, in0_tail, in1_head, in1_tail  input  1 each  packet framing flags.
REQ-008 SHALL have ports in0_ready / in1_ready  output  1  FIFO not full.
REQ-009 SHALL have ports vc0_flit / vc1_flit  output  FLIT_W  FIFO head payload, drives mux inputs i0 / i1.
REQ-010 SHALL have port sel  output  1  VC select to downstream mux (0 = VC0, 1 = VC1).
REQ-011 SHALL have ports out_valid, out_head, out_tail  output  1 each  selected flit valid and its framing.
REQ-012 SHALL have port out_ready  input  1  downstream accepts selected flit.
REQ-013 SHALL have port err  output  1  sticky framing-error flag.

Function
REQ-014 SHALL push inN flit+flags into FIFO N when inN_valid && inN_ready; inN_ready = FIFO N not full (no pass-through on full).
REQ-015 SHALL present FIFO N head on vcN_flit one cycle after the write into an empty FIFO; vcN_flit = 0 when FIFO N empty.
REQ-016 SHALL implement FSM states IDLE, LOCK0, LOCK1; state registered.
REQ-017 IDLE: if exactly one FIFO head is a head flit, grant that VC; if both, grant VC indicated by round-robin pointer rr; transition to LOCKx on next edge, sel <= x.
REQ-018 IDLE: a non-empty FIFO whose head flit lacks head flag SHALL be popped (discarded) and err set; discard on both VCs in the same cycle allowed.
REQ-019 LOCKx: out_valid = FIFO x non-empty; out_head/out_tail = FIFO x head flags; sel held at x.
REQ-020 Transfer SHALL occur when out_valid && out_ready, popping FIFO x; FIFO of other VC untouched.
REQ-021 Transfer of a tail flit SHALL return FSM to IDLE and set rr to the other VC; single flit with head&&tail is a complete packet.
REQ-022 LOCKx with FIFO x empty SHALL hold lock, out_valid = 0 (wormhole; no interleaving).
REQ-023 out_valid SHALL be 0 in IDLE; first flit latency = 2 cycles from write to out_valid (write N, head visible N+1, grant edge end of N+1, out_valid N+2).
REQ-024 Simultaneous push and pop on one FIFO SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-025 out_valid SHALL not drop without a transfer while in LOCKx and FIFO non-empty (no withdrawal).

Reset
REQ-026 rst_n low SHALL asynchronously clear: FSM = IDLE, rr = 0, sel = 0, both FIFOs empty (pointers/count 0), err = 0.
REQ-027 During and after reset: in0_ready = in1_ready = 0 while rst_n low, 1 from first edge after release; out_valid, out_head, out_tail = 0; vc0_flit = vc1_flit = 0.
REQ-028 Reset mid-packet SHALL drop all buffered flits; no partial packet emitted after release.

Structure
REQ-029 Shared package SHALL hold FLIT_W default, DEPTH default, FSM state encoding, and a flit record (payload, head, tail).
REQ-030 SHALL instantiate one sub-module vc_fifo (synchronous FIFO, registered pointers, count) twice, one per VC.
REQ-031 Arbiter FSM and output muxing SHALL reside in vc_input_arbiter; sel SHALL be a flop output.

Verification
REQ-032 Single flit 0xA5A5_0001 head&&tail on VC0, out_ready=1 -> out_valid at cycle +2, sel=0, vc0_flit=0xA5A5_0001, FSM back to IDLE, rr=1.
REQ-033 Both VCs present 3-flit packets same cycle, rr=0 -> VC0 packet fully transferred (sel=0), then VC1 (sel=1), no interleave.
REQ-034 Fill VC1 with 4 flits, out_ready=0 -> in1_ready=0 after 4th push; 5th offered flit not accepted; release out_ready -> 4 flits out in order.
REQ-035 Body flit 0x0000_00FF without head on VC0 in IDLE -> popped, err=1 sticky, out_valid stays 0.
REQ-036 Assert rst_n=0 after 2 of 3 flits transferred -> all outputs to reset values immediately; after release, no further flits of that packet appear.
REQ-037 Continuous push/pop at full rate on VC0 for 20 flits with DEPTH=4 -> pointer wrap, order preserved, count never exceeds 4.
